quad_write_octa_read_mem: RTL and testbench

- Register-file style data memory for the vector datapath.
- Writes four consecutive 32-bit words per clock and reads eight consecutive 32-bit words combinationally.
- Feeds vector operand fetch in the ID stage, and accepts vector results written back four lanes at a time.

---
 rtl/quad_write_octa_read_mem_if.sv | 20 ++
 rtl/quad_write_octa_read_mem.sv | 72 +++++++
 tb/tb_quad_write_octa_read_mem.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/quad_write_octa_read_mem_if.sv
// Bus bundle for quad_write_octa_read_mem: four-word write port plus eight-word read port.
interface quad_write_octa_read_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wd1, wd2, wd3, wd4;
  logic [DATA_W-1:0] out1, out2, out3, out4, out5, out6, out7, out8;

  modport master (
    output we, wr_addr, rd_addr, wd1, wd2, wd3, wd4,
    input  out1, out2, out3, out4, out5, out6, out7, out8
  );
  modport slave (
    input  we, wr_addr, rd_addr, wd1, wd2, wd3, wd4,
    output out1, out2, out3, out4, out5, out6, out7, out8
  );
endinterface

// File: rtl/quad_write_octa_read_mem.sv
// Vector register-file memory: 4 wrapping word writes per clock, 8 wrapping word reads.
// Define MULT_MEM_OUT_REG_EN to register the read outputs (1-cycle, read-before-write).
module quad_write_octa_read_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
) (
  input logic                         clk,
  input logic                         rst_n,
  quad_write_octa_read_mem_if.slave   bus
);
  localparam int AW      = $clog2(DEPTH);
  localparam int WLANES  = 4;
  localparam int RLANES  = 8;

  logic [AW-1:0]                  wbase, rbase;
  logic [WLANES-1:0][DATA_W-1:0]  wd;
  logic [RLANES-1:0][DATA_W-1:0]  rd;
  logic [DATA_W-1:0]              mem_q [DEPTH];
  logic [DATA_W-1:0]              mem_d [DEPTH];
  logic                           unused_addr_hi;

  // Only the low index bits address the array; bursts wrap modulo DEPTH.
  assign wbase          = bus.wr_addr[AW-1:0];
  assign rbase          = bus.rd_addr[AW-1:0];
  assign unused_addr_hi = ^{bus.wr_addr[ADDR_W-1:AW], bus.rd_addr[ADDR_W-1:AW]};
  assign wd             = {bus.wd4, bus.wd3, bus.wd2, bus.wd1};

  always_comb begin
    mem_d = mem_q;
    if (bus.we) begin
      for (int k = 0; k < WLANES; k++)
        mem_d[wbase + AW'(k)] = wd[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar g = 0; g < RLANES; g++) begin : g_rd
    assign rd[g] = mem_q[rbase + AW'(g)];
  end

`ifdef MULT_MEM_OUT_REG_EN
  logic [RLANES-1:0][DATA_W-1:0] out_q, out_d;

  // mem_q is still the pre-edge contents here, giving read-before-write.
  always_comb out_d = rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end
`else
  logic [RLANES-1:0][DATA_W-1:0] out_q;
  assign out_q = rd;
`endif

  assign bus.out1 = out_q[0];
  assign bus.out2 = out_q[1];
  assign bus.out3 = out_q[2];
  assign bus.out4 = out_q[3];
  assign bus.out5 = out_q[4];
  assign bus.out6 = out_q[5];
  assign bus.out7 = out_q[6];
  assign bus.out8 = out_q[7];
endmodule

// File: tb/tb_quad_write_octa_read_mem.sv
// Self-checking bench for quad_write_octa_read_mem: directed table, hand sequences, random vs array model.
module tb_quad_write_octa_read_mem;
  localparam int DW = 32;
  localparam int DEPTH = 64;
  typedef logic [7:0][DW-1:0] rd8_t;
  typedef logic [3:0][DW-1:0] wd4_t;

  typedef struct {
    bit          we;
    logic [31:0] wa;
    wd4_t        wd;
    logic [31:0] ra;
    rd8_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [DW-1:0] model [DEPTH];
  vec_t tbl [7];

  quad_write_octa_read_mem_if #(.DATA_W(DW), .ADDR_W(32)) bus ();
  quad_write_octa_read_mem #(.DATA_W(DW), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic rd8_t got_outs();
    return {bus.out8, bus.out7, bus.out6, bus.out5, bus.out4, bus.out3, bus.out2, bus.out1};
  endfunction

  function automatic rd8_t model_rd(input logic [31:0] ra);
    rd8_t r;
    for (int k = 0; k < 8; k++) r[k] = model[(int'(ra % DEPTH) + k) % DEPTH];
    return r;
  endfunction

  function automatic rd8_t pack8(input int a, b, c, d, e, f, g, h);
    return {DW'(h), DW'(g), DW'(f), DW'(e), DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic wd4_t pack4(input int a, b, c, d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  task automatic check(input string name, input rd8_t exp);
    rd8_t got;
    got = got_outs();
    checks++;
    if (got !== exp) begin
      errors++;
      for (int k = 0; k < 8; k++)
        if (got[k] !== exp[k])
          $display("FAIL %s out%0d: got %0d want %0d", name, k + 1, got[k], exp[k]);
    end
  endtask

  // One clock: drive at negedge, update model, compare 1 time unit after the edge.
  task automatic step(input bit w, input logic [31:0] wa, input wd4_t wd,
                      input logic [31:0] ra, input string name);
    rd8_t exp;
    @(negedge clk);
    bus.we = w; bus.wr_addr = wa; bus.rd_addr = ra;
    bus.wd1 = wd[0]; bus.wd2 = wd[1]; bus.wd3 = wd[2]; bus.wd4 = wd[3];
`ifdef MULT_MEM_OUT_REG_EN
    exp = model_rd(ra);
`endif
    if (w) for (int k = 0; k < 4; k++) model[(int'(wa % DEPTH) + k) % DEPTH] = wd[k];
`ifndef MULT_MEM_OUT_REG_EN
    exp = model_rd(ra);
`endif
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    rd8_t hold;
    tbl[0] = '{1'b0, 32'd0,  pack4(0, 0, 0, 0),       32'd0,  pack8(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{1'b1, 32'd0,  pack4(50, 100, 11, 23),  32'd0,  pack8(50, 100, 11, 23, 0, 0, 0, 0)};
    tbl[2] = '{1'b1, 32'd4,  pack4(50, 100, 11, 23),  32'd0,  pack8(50, 100, 11, 23, 50, 100, 11, 23)};
    tbl[3] = '{1'b0, 32'd0,  pack4(1, 2, 3, 4),       32'd0,  pack8(50, 100, 11, 23, 50, 100, 11, 23)};
    tbl[4] = '{1'b1, 32'd62, pack4(7, 8, 9, 10),      32'd62, pack8(7, 8, 9, 10, 11, 23, 50, 100)};
    tbl[5] = '{1'b0, 32'd0,  pack4(0, 0, 0, 0),       32'd0,  pack8(9, 10, 11, 23, 50, 100, 11, 23)};
    tbl[6] = '{1'b1, 32'hFFFF_FF08, pack4(1, 2, 3, 4), 32'h0000_0106, pack8(11, 23, 1, 2, 3, 4, 0, 0)};

    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    bus.we = 1'b0; bus.wr_addr = '0; bus.rd_addr = '0;
    bus.wd1 = '0; bus.wd2 = '0; bus.wd3 = '0; bus.wd4 = '0;

    #2 check("in_reset", '0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 check("after_release", '0);

    // Each entry: a write cycle, a few idle cycles, then a read cycle checked against constants.
    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, $sformatf("tbl%0d_wr", i));
      repeat (2) step(1'b0, tbl[i].wa, tbl[i].wd, tbl[i].ra, $sformatf("tbl%0d_idle", i));
      step(1'b0, 32'd0, pack4(0, 0, 0, 0), tbl[i].ra, $sformatf("tbl%0d_rdm", i));
      check($sformatf("tbl%0d_const", i), tbl[i].exp);
    end

    // Mid-cycle rd_addr change: comb outputs follow at once, registered ones hold.
    step(1'b0, 32'd0, pack4(0, 0, 0, 0), 32'd0, "pre_mid");
    hold = model_rd(32'd0);
    @(negedge clk);
    bus.rd_addr = 32'd60;
    #1;
`ifdef MULT_MEM_OUT_REG_EN
    check("mid_rd_hold", hold);
`else
    check("mid_rd_comb", model_rd(32'd60));
`endif
    @(posedge clk); #1 check("mid_rd_edge", model_rd(32'd60));

    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(1)), $urandom(),
           {$urandom(), $urandom(), $urandom(), $urandom()},
           $urandom(), $sformatf("rand%0d", n));

    // Async reset between edges, with a write held across a reset edge.
    step(1'b1, 32'd20, pack4(5, 6, 7, 8), 32'd20, "pre_rst");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", '0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    bus.we = 1'b1; bus.wr_addr = 32'd40; bus.rd_addr = 32'd40;
    @(posedge clk); #1 check("rst_write_lost_hold", '0);
    @(negedge clk); rst_n = 1'b1; bus.we = 1'b0;
    #1 check("rst_released", '0);
    step(1'b0, 32'd0, pack4(0, 0, 0, 0), 32'd40, "rst_write_lost");
    step(1'b0, 32'd0, pack4(0, 0, 0, 0), 32'd20, "rst_cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
